// File: rtl/sprite_walk_sequencer_pkg.sv
// sprite_pkg: shared constants and types for the walking-sprite controller.
//   SPR_W/SPR_H     sprite box size in pixels
//   H_ACTIVE/V_ACTIVE visible screen size
//   FRAME_WORDS     ROM words occupied by one walk frame
//   walk_state_t    animation state machine states
package sprite_pkg;
    localparam int SPR_W       = 100;
    localparam int SPR_H       = 100;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int FRAME_WORDS = SPR_W * SPR_H;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        SETTLE = 2'd2
    } walk_state_t;
endpackage

// File: rtl/sprite_walk_sequencer_if.sv
// sprite_walk_sequencer_if: bundles the pixel-timing inputs, sprite control
// inputs and ROM-address outputs of the walking-sprite controller.
//   master: VGA timing / game logic side (drives DrawX, DrawY, blank,
//           walk_en, dir, pos_x, pos_y; receives address, hit, frame, tick)
//   slave : the sprite controller itself
interface sprite_walk_sequencer_if #(
    parameter int NUM_FRAMES = 4,
    parameter int ADDR_W     = 16
);
    localparam int FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic              walk_en;
    logic              dir;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic [ADDR_W-1:0] rom_address;
    logic              sprite_hit;
    logic [FI_W-1:0]   frame_idx;
    logic              frame_tick;

    modport master (
        output DrawX, DrawY, blank, walk_en, dir, pos_x, pos_y,
        input  rom_address, sprite_hit, frame_idx, frame_tick
    );

    modport slave (
        input  DrawX, DrawY, blank, walk_en, dir, pos_x, pos_y,
        output rom_address, sprite_hit, frame_idx, frame_tick
    );
endinterface

// File: rtl/sprite_walk_sequencer_vga_frame_tick.sv
// vga_frame_tick: one-cycle pulse on the first cycle the beam sits at (0,0).
//   clk, reset      pixel clock, synchronous active-high reset
//   draw_x, draw_y  current beam position
//   frame_tick      high for one cycle at the start of each screen
module vga_frame_tick (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    output logic       frame_tick
);
    logic match;
    logic prev_d, prev_q;

    assign match      = (draw_x == 10'd0) && (draw_y == 10'd0);
    // prev_q clears on reset so a release while parked at (0,0) still ticks.
    assign frame_tick = match && !prev_q;

    always_comb begin
        prev_d = match;
    end

    always_ff @(posedge clk) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= prev_d;
    end
endmodule

// File: rtl/sprite_walk_sequencer.sv
// sprite_walk_sequencer: walk-cycle animation and sprite ROM addressing.
//   vga_clk, reset  pixel clock, synchronous active-high reset
//   bus (slave)     DrawX/DrawY/blank beam position, walk_en/dir/pos_x/pos_y
//                   sprite controls; rom_address/sprite_hit registered one
//                   cycle after the pixel, frame_idx current walk frame,
//                   frame_tick start-of-screen pulse.
module sprite_walk_sequencer
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES      = 4,
    parameter int TICKS_PER_FRAME = 6,
    parameter int ADDR_W          = 16
) (
    input  logic                    vga_clk,
    input  logic                    reset,
    sprite_walk_sequencer_if.slave  bus
);
    localparam int FI_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int CNT_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_WALK   = WALK;
    localparam logic [1:0] ST_SETTLE = SETTLE;

    logic tick;

    logic [1:0]        state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [FI_W-1:0]   frame_d, frame_q;
    logic [9:0]        px_d, px_q, py_d, py_q;
    logic              pdir_d, pdir_q;
    logic [ADDR_W-1:0] rom_address_d, rom_address_q;
    logic              sprite_hit_d, sprite_hit_q;

    vga_frame_tick u_frame_tick (
        .clk        (vga_clk),
        .reset      (reset),
        .draw_x     (bus.DrawX),
        .draw_y     (bus.DrawY),
        .frame_tick (tick)
    );

    // Animation state and latched sprite placement only move on ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        px_d    = px_q;
        py_d    = py_q;
        pdir_d  = pdir_q;
        if (tick) begin
            px_d   = bus.pos_x;
            py_d   = bus.pos_y;
            pdir_d = bus.dir;
            case (state_q)
                ST_IDLE: begin
                    frame_d = '0;
                    if (bus.walk_en) begin
                        state_d = ST_WALK;
                        cnt_d   = '0;
                    end
                end
                ST_WALK: begin
                    if (!bus.walk_en) begin
                        state_d = ST_SETTLE;
                    end else if (cnt_q == CNT_W'(TICKS_PER_FRAME - 1)) begin
                        cnt_d   = '0;
                        frame_d = (frame_q == FI_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    cnt_d = '0;
                    if (bus.walk_en) begin
                        state_d = ST_WALK;
                    end else begin
                        state_d = ST_IDLE;
                        frame_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    frame_d = '0;
                end
            endcase
        end
    end

    // Address math uses the post-tick placement and frame so the whole
    // screen that starts at a tick, including its first pixel, is consistent.
    logic [10:0] x11, y11, px11, py11;
    logic        in_box;
    logic [6:0]  col_raw, col, row;

    always_comb begin
        x11     = {1'b0, bus.DrawX};
        y11     = {1'b0, bus.DrawY};
        px11    = {1'b0, px_d};
        py11    = {1'b0, py_d};
        in_box  = (x11 >= px11) && (x11 < px11 + 11'(SPR_W)) &&
                  (y11 >= py11) && (y11 < py11 + 11'(SPR_H)) && bus.blank;
        col_raw = 7'(bus.DrawX - px_d);
        row     = 7'(bus.DrawY - py_d);
        col     = pdir_d ? 7'(SPR_W - 1) - col_raw : col_raw;
        // Outside the box the offset is forced to zero so the address
        // parks on the frame base rather than toggling.
        rom_address_d = ADDR_W'(frame_d) * ADDR_W'(FRAME_WORDS)
                      + (in_box ? ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col) : '0);
        sprite_hit_d  = in_box;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            frame_q       <= '0;
            px_q          <= '0;
            py_q          <= '0;
            pdir_q        <= 1'b0;
            rom_address_q <= '0;
            sprite_hit_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_q       <= frame_d;
            px_q          <= px_d;
            py_q          <= py_d;
            pdir_q        <= pdir_d;
            rom_address_q <= rom_address_d;
            sprite_hit_q  <= sprite_hit_d;
        end
    end

    assign bus.rom_address = rom_address_q;
    assign bus.sprite_hit  = sprite_hit_q;
    assign bus.frame_idx   = frame_q;
    assign bus.frame_tick  = tick;
endmodule

// File: tb/tb_sprite_walk_sequencer.sv
module tb_sprite_walk_sequencer;
    import sprite_pkg::*;

    localparam int NF  = 4;
    localparam int TPF = 6;
    localparam int AW  = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_walk_sequencer_if #(.NUM_FRAMES(NF), .ADDR_W(AW)) bus ();

    sprite_walk_sequencer #(
        .NUM_FRAMES      (NF),
        .TICKS_PER_FRAME (TPF),
        .ADDR_W          (AW)
    ) dut (
        .vga_clk (clk),
        .reset   (reset),
        .bus     (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int tick_seen = 0;

    // Reference model: animation mode, frame, ticks spent walking,
    // latched placement, previous (0,0) flag.
    walk_state_t m_state;
    int          m_frame;
    int          m_walk_ticks;
    int          m_px, m_py;
    bit          m_pdir;
    bit          m_prev;
    int          frame_seq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = IDLE; m_frame = 0; m_walk_ticks = 0;
        m_px = 0; m_py = 0; m_pdir = 0; m_prev = 0;
    endtask

    task automatic model_tick();
        m_px = int'(bus.pos_x); m_py = int'(bus.pos_y); m_pdir = bus.dir;
        case (m_state)
            IDLE: begin
                m_frame = 0;
                if (bus.walk_en) begin m_state = WALK; m_walk_ticks = 0; end
            end
            WALK: begin
                if (!bus.walk_en) m_state = SETTLE;
                else begin
                    m_walk_ticks++;
                    if (m_walk_ticks % TPF == 0) m_frame = (m_frame + 1) % NF;
                end
            end
            default: begin
                if (bus.walk_en) begin m_state = WALK; m_walk_ticks = 0; end
                else begin m_state = IDLE; m_frame = 0; end
            end
        endcase
    endtask

    task automatic step(input int x, input int y);
        bit b, match, et, eh;
        int ea;
        b = (x < H_ACTIVE) && (y < V_ACTIVE);
        bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.blank = b;
        #1;
        match = (x == 0) && (y == 0);
        et = match && !m_prev;
        chk("frame_tick", bus.frame_tick, et);
        if (bus.frame_tick === 1'b1) tick_seen++;
        @(posedge clk);
        m_prev = match;
        if (et) model_tick();
        eh = b && x >= m_px && x < m_px + 100 && y >= m_py && y < m_py + 100;
        ea = m_frame * 10000;
        if (eh) ea += (y - m_py) * 100 + (m_pdir ? 99 - (x - m_px) : (x - m_px));
        #1;
        chk("rom_address", bus.rom_address, ea);
        chk("sprite_hit", bus.sprite_hit, eh);
        chk("frame_idx", bus.frame_idx, m_frame);
    endtask

    task automatic do_reset(input int x, input int y);
        reset = 1'b1;
        bus.DrawX = 10'(x); bus.DrawY = 10'(y);
        bus.blank = (x < H_ACTIVE) && (y < V_ACTIVE);
        @(posedge clk);
        model_reset();
        #1;
        chk("rst_rom_address", bus.rom_address, 0);
        chk("rst_sprite_hit", bus.sprite_hit, 0);
        chk("rst_frame_idx", bus.frame_idx, 0);
        reset = 1'b0;
    endtask

    task automatic rand_pixel(output int x, output int y);
        if ($urandom_range(0, 3) == 0) begin
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 524);
        end else begin
            x = m_px + $urandom_range(0, 120) - 10;
            y = m_py + $urandom_range(0, 120) - 10;
            if (x < 0) x = 0;
            if (x > 799) x = 799;
            if (y < 0) y = 0;
            if (y > 524) y = 524;
        end
        if (x == 0 && y == 0) x = 1;
    endtask

    // One screen: beam parks on (0,0) for two cycles, then wanders.
    task automatic screen(input int n_pix);
        int x, y;
        step(0, 0);
        step(0, 0);
        for (int i = 0; i < n_pix; i++) begin
            rand_pixel(x, y);
            step(x, y);
        end
    endtask

    task automatic record_frame();
        if (frame_seq.size() == 0 || frame_seq[$] != int'(bus.frame_idx))
            frame_seq.push_back(int'(bus.frame_idx));
    endtask

    initial begin
        int guard;
        bus.DrawX = 10'd5; bus.DrawY = 10'd5; bus.blank = 1'b1;
        bus.walk_en = 1'b0; bus.dir = 1'b0;
        bus.pos_x = 10'd0; bus.pos_y = 10'd0;
        model_reset();
        do_reset(5, 5);

        // Idle for three screens.
        tick_seen = 0;
        for (int s = 0; s < 3; s++) begin
            bus.pos_x = 10'($urandom_range(0, 639));
            bus.pos_y = 10'($urandom_range(0, 479));
            bus.dir   = 1'($urandom_range(0, 1));
            screen(6);
        end
        chk("idle_tick_count", tick_seen, 3);
        chk("idle_frame", bus.frame_idx, 0);
        chk("idle_state", dut.state_q, IDLE);

        // Walk for 30 screens; observed frame sequence must be 0,1,2,3,0.
        bus.walk_en = 1'b1;
        frame_seq.delete();
        for (int s = 0; s < 30; s++) begin
            bus.pos_x = 10'($urandom_range(0, 639));
            bus.pos_y = 10'($urandom_range(0, 479));
            bus.dir   = 1'($urandom_range(0, 1));
            screen(4);
            record_frame();
        end
        chk("walk_seq_len", frame_seq.size(), 5);
        for (int i = 0; i < 5 && i < frame_seq.size(); i++)
            chk("walk_seq", frame_seq[i], i % NF);

        // Reach frame 2, then settle there with a known placement.
        guard = 0;
        while (m_frame != 2 && guard < 40) begin screen(1); guard++; end
        chk("reach_frame2", m_frame, 2);
        bus.walk_en = 1'b0; bus.pos_x = 10'd200; bus.pos_y = 10'd100; bus.dir = 1'b0;
        screen(0);
        step(250, 150);
        chk("addr_right", bus.rom_address, 25050);
        chk("hit_right", bus.sprite_hit, 1);
        step(300, 150);
        chk("miss_right_edge", bus.sprite_hit, 0);
        bus.dir = 1'b1;
        step(250, 150);
        chk("dir_midscreen", bus.rom_address, 25050);
        bus.walk_en = 1'b1;
        screen(0);
        step(250, 150);
        chk("addr_left", bus.rom_address, 25049);

        // Partially off-screen sprite at the right edge.
        bus.dir = 1'b0; bus.pos_x = 10'd600; bus.pos_y = 10'd0;
        screen(0);
        step(639, 10);
        chk("edge_addr", bus.rom_address, 20000 + 1000 + 39);
        chk("edge_hit", bus.sprite_hit, 1);
        step(640, 10);
        chk("offscreen_hit", bus.sprite_hit, 0);
        chk("offscreen_addr", bus.rom_address, 20000);

        // Walk to frame 3, then settle and return to idle.
        guard = 0;
        while (m_frame != 3 && guard < 40) begin screen(1); guard++; end
        chk("reach_frame3", m_frame, 3);
        bus.walk_en = 1'b0;
        screen(2);
        chk("settle_frame", bus.frame_idx, 3);
        chk("settle_state", dut.state_q, SETTLE);
        screen(2);
        chk("idle_again_frame", bus.frame_idx, 0);
        chk("idle_again_state", dut.state_q, IDLE);

        // Reset in the middle of a line while inside the box.
        bus.walk_en = 1'b1; bus.pos_x = 10'd10; bus.pos_y = 10'd10;
        for (int s = 0; s < 8; s++) screen(2);
        step(50, 50);
        do_reset(60, 50);
        step(50, 50);
        chk("post_reset_addr", bus.rom_address, 5050);

        // Randomised screens with changing controls.
        for (int s = 0; s < 60; s++) begin
            bus.walk_en = 1'($urandom_range(0, 3) != 0);
            bus.pos_x = 10'($urandom_range(0, 639));
            bus.pos_y = 10'($urandom_range(0, 479));
            bus.dir   = 1'($urandom_range(0, 1));
            step(0, 0);
            for (int i = 0; i < 15; i++) begin
                int x, y;
                if (i == 5) begin
                    bus.pos_x = 10'($urandom_range(0, 639));
                    bus.dir   = ~bus.dir;
                end
                rand_pixel(x, y);
                step(x, y);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sprite_walk_sequencer.md
# sprite_walk_sequencer

- Animation and addressing controller for one 100x100 walking sprite.
- Steps the walk frames once per N screen refreshes and latches the sprite position and facing at frame boundaries.
- Generates the address into a frame-stacked sprite ROM plus an aligned in-box flag.
- Sits between the VGA timing counters (DrawX/DrawY/blank) and the sprite ROM/palette/colour register stage of the display path.

## Interface
Parameters:
- NUM_FRAMES, 4: walk frames stacked in ROM, frame f occupies words f*10000 .. f*10000+9999
- TICKS_PER_FRAME, 6: screen refreshes per animation step, at least 1
- ADDR_W, 16: ROM address width, must satisfy 2^ADDR_W >= NUM_FRAMES*10000

Ports:
- Clocking and reset (already decided): one clock, `vga_clk`; reset is `reset`, synchronous and active-high.
- vga_clk  in  1  pixel clock; all state on posedge
- reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column, 0..799
- DrawY  in  10  current pixel row, 0..524
- blank  in  1  high = active video
- walk_en  in  1  request walking animation (level)
- dir  in  1  0 = face right, 1 = face left (horizontal mirror)
- pos_x  in  10  requested sprite top-left column
- pos_y  in  10  requested sprite top-left row
- rom_address  out  ADDR_W  sprite ROM address, registered
- sprite_hit  out  1  current registered address lies inside the sprite box during active video
- frame_idx  out  $clog2(NUM_FRAMES)  currently displayed frame
- frame_tick  out  1  one-cycle pulse at start of each screen

## Operation
- **Frame tick.** `frame_tick` = 1 for exactly one cycle when (DrawX,DrawY) == (0,0) and the previous cycle's pair was not (0,0). The previous-match flag resets to 0, so a reset released while at (0,0) produces a tick on the first cycle.
- **Latching at ticks.** On each tick, pos_x/pos_y/dir are latched into px/py/pdir. Address math uses only latched values, so there is no tearing mid-screen.
- **State machine.** Evaluated on tick cycles only; walk_en is ignored between ticks.
  - **IDLE**, frame 0. Tick with walk_en=1 → WALK, tick counter cleared to 0.
  - **WALK.** Each tick, tick counter +1. When it reaches TICKS_PER_FRAME-1 it clears and frame_idx advances, with (NUM_FRAMES-1) → 0 wraparound. A tick with walk_en=0 → SETTLE, frame unchanged.
  - **SETTLE.** Next tick with walk_en=1 → WALK, counter cleared, frame kept. Next tick with walk_en=0 → IDLE, frame_idx=0.
- **Box test.** 11-bit compares, no wrap:
  - in_box = DrawX >= px && DrawX < px+100 && DrawY >= py && DrawY < py+100 && blank.
  - The sprite may be partially off-screen (px up to 639). Pixels past column 639 or row 479 never hit, because blank is low there.
- **Addressing.**
  - col = DrawX-px when pdir=0, else 99-(DrawX-px); row = DrawY-py.
  - rom_address = frame_idx*10000 + row*100 + col, using constant multiplies and no dividers.
  - Outside the box: rom_address = frame_idx*10000 (a don't-care value, held deterministic) and sprite_hit = 0.
- **Reset values.** rom_address=0, sprite_hit=0, frame_idx=0, frame_tick=0, state IDLE, tick counter 0, px=py=0, pdir=0.

## Timing
- Inputs sampled at posedge k; rom_address and sprite_hit are valid after posedge k+1 (latency 1).
- The downstream ROM samples rom_address on the negedge inside cycle k+1. The colour register samples palette output at posedge k+2 and must use sprite_hit delayed by one stage, which the consumer does.
- frame_tick asserts in the same cycle as the (0,0) match (combinational from DrawX/DrawY and the registered previous match). The state, frame_idx and latched position update at the following posedge.
- A frame_idx change takes effect on the first pixel of the screen that produced the tick.
- Reset mid-screen: outputs return to reset values next edge; the sprite reappears at the next tick with position latched then. Between reset and that tick, px=py=0.

## Structure
- Package `sprite_pkg`:
  - SPR_W=100, SPR_H=100, H_ACTIVE=640, V_ACTIVE=480
  - typedef enum {IDLE, WALK, SETTLE} walk_state_t
  - localparam FRAME_WORDS = SPR_W*SPR_H
- Sub-module `vga_frame_tick`: (0,0) edge detector producing frame_tick, reused by other sprite controllers.

## Test plan
- Reset, walk_en=0, run 3 screens → frame_idx stays 0, state IDLE, exactly 3 frame_tick pulses, each 1 cycle wide.
- walk_en=1, TICKS_PER_FRAME=6, NUM_FRAMES=4, run 30 screens → frame_idx sequence 0,1,2,3,0 changing every 6 ticks, wrapping at 3→0.
- pos=(200,100), dir=0, frame 2, pixel (250,150) → rom_address=25050 one cycle later, sprite_hit=1. Pixel (300,150) → sprite_hit=0.
- Same pixel with dir=1 → rom_address = 20000+5000+49 = 25049. Changing dir mid-screen has no effect until the next tick.
- pos_x=600, pixel (639,10) with py=0 → hit with col=39. Pixel (640,10) with blank=0 → sprite_hit=0, no wrap to column 0.
- Walking at frame 3, drop walk_en → SETTLE at next tick (frame 3 held), IDLE with frame 0 at the tick after. Assert reset mid-line → all outputs 0 next edge.
